// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: bus word, RAM handshake state, and the arbiter's
// state and grant encodings.
package cpu_types_pkg;

  localparam int CPUS = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic {
    IDLE,
    SERVE
  } arb_state_t;

  typedef struct packed {
    logic core;
    logic isData;
    logic isWrite;
  } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-control bundle widened to one I/D port pair per core plus the shared
// RAM port; master is the arbiter side, slave the caches/RAM side.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN   [CPUS];
  word_t     iaddr  [CPUS];
  logic      dREN   [CPUS];
  logic      dWEN   [CPUS];
  word_t     daddr  [CPUS];
  word_t     dstore [CPUS];
  logic      iwait  [CPUS];
  logic      dwait  [CPUS];
  word_t     iload  [CPUS];
  word_t     dload  [CPUS];

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter.sv
// Serialises per-core instruction/data requests onto one RAM port: data beats
// instruction within a core, cores alternate round-robin on a tie.
module mem_arbiter
  import cpu_types_pkg::*;
(
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.master ccif
);

  arb_state_t      state_q, state_d;
  grant_t          grant_q, grant_d;
  logic            last_q, last_d;
  logic [CPUS-1:0] data_req;
  logic [CPUS-1:0] core_req;
  logic            granted_live;

  generate
    for (genvar gi = 0; gi < CPUS; gi++) begin : g_req
      assign data_req[gi] = ccif.dREN[gi] | ccif.dWEN[gi];
      assign core_req[gi] = data_req[gi] | ccif.iREN[gi];
    end
  endgenerate

  // last starts at 1 so core0 wins the first tie after reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_d         = last_q;
    ccif.ramREN    = 1'b0;
    ccif.ramWEN    = 1'b0;
    ccif.ramaddr   = '0;
    ccif.ramstore  = '0;
    for (int c = 0; c < CPUS; c++) begin
      ccif.iwait[c] = 1'b1;
      ccif.dwait[c] = 1'b1;
      ccif.iload[c] = '0;
      ccif.dload[c] = '0;
    end
    granted_live = grant_q.isData ? data_req[grant_q.core]
                                  : ccif.iREN[grant_q.core];

    case (state_q)
      IDLE: begin
        if (|core_req) begin
          grant_d.core    = (&core_req) ? ~last_q : core_req[1];
          grant_d.isData  = data_req[grant_d.core];
          grant_d.isWrite = ccif.dWEN[grant_d.core];
          state_d         = SERVE;
        end
      end
      SERVE: begin
        // A withdrawn request is dropped silently; the RAM port goes quiet.
        if (!granted_live) begin
          state_d = IDLE;
        end else begin
          ccif.ramREN   = ~grant_q.isWrite;
          ccif.ramWEN   = grant_q.isWrite;
          ccif.ramaddr  = grant_q.isData ? ccif.daddr[grant_q.core]
                                         : ccif.iaddr[grant_q.core];
          ccif.ramstore = ccif.dstore[grant_q.core];
          if (ccif.ramstate == ACCESS) begin
            if (grant_q.isData) begin
              ccif.dwait[grant_q.core] = 1'b0;
              ccif.dload[grant_q.core] = ccif.ramload;
            end else begin
              ccif.iwait[grant_q.core] = 1'b0;
              ccif.iload[grant_q.core] = ccif.ramload;
            end
            last_d  = grant_q.core;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter against a transaction-level model of the
// arbitration rules, plus directed single-read, write, abort and reset cases.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .CLK  (CLK),
    .nRST (nRST),
    .ccif (bus.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%08h want=%08h", tag, obs, exp);
    end
  endtask

  // Model: "busy" means some source owns the RAM; which source is recorded
  // by core number and access kind.
  bit m_busy = 0, m_data = 0, m_write = 0;
  int m_core = 0, m_last = 1;
  bit n_busy, n_data, n_write;
  int n_core, n_last;
  bit done_i [2];
  bit done_d [2];

  task automatic eval_and_check();
    bit    e_ren, e_wen;
    word_t e_addr, e_store;
    bit    e_iw [2];
    bit    e_dw [2];
    word_t e_il [2];
    word_t e_dl [2];
    int    want [$];
    bit    live;
    e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
    for (int c = 0; c < 2; c++) begin
      e_iw[c] = 1; e_dw[c] = 1; e_il[c] = 0; e_dl[c] = 0;
      done_i[c] = 0; done_d[c] = 0;
    end
    n_busy = m_busy; n_data = m_data; n_write = m_write;
    n_core = m_core; n_last = m_last;

    if (!nRST) begin
      n_busy = 0; n_last = 1;
    end else if (!m_busy) begin
      for (int c = 0; c < 2; c++)
        if (bus.iREN[c] || bus.dREN[c] || bus.dWEN[c]) want.push_back(c);
      if (want.size() > 0) begin
        n_core  = (want.size() == 2) ? 1 - m_last : want[0];
        n_data  = bus.dREN[n_core] || bus.dWEN[n_core];
        n_write = bus.dWEN[n_core];
        n_busy  = 1;
      end
    end else begin
      live = m_data ? (bus.dREN[m_core] || bus.dWEN[m_core]) : bus.iREN[m_core];
      if (!live) begin
        n_busy = 0;
      end else begin
        e_ren   = !m_write;
        e_wen   = m_write;
        e_addr  = m_data ? bus.daddr[m_core] : bus.iaddr[m_core];
        e_store = bus.dstore[m_core];
        if (bus.ramstate == ACCESS) begin
          if (m_data) begin
            e_dw[m_core] = 0; e_dl[m_core] = bus.ramload; done_d[m_core] = 1;
          end else begin
            e_iw[m_core] = 0; e_il[m_core] = bus.ramload; done_i[m_core] = 1;
          end
          n_last = m_core;
          n_busy = 0;
          $display("txn core%0d %s addr=%08h data=%08h", m_core,
                   m_data ? (m_write ? "write " : "dread ") : "ifetch",
                   e_addr, m_write ? e_store : bus.ramload);
        end
      end
    end

    check_eq("ramREN",   32'(bus.ramREN), 32'(e_ren));
    check_eq("ramWEN",   32'(bus.ramWEN), 32'(e_wen));
    check_eq("ramaddr",  bus.ramaddr,  e_addr);
    check_eq("ramstore", bus.ramstore, e_store);
    check_eq("waits",
             32'({bus.iwait[0], bus.iwait[1], bus.dwait[0], bus.dwait[1]}),
             32'({e_iw[0], e_iw[1], e_dw[0], e_dw[1]}));
    check_eq("iload0", bus.iload[0], e_il[0]);
    check_eq("iload1", bus.iload[1], e_il[1]);
    check_eq("dload0", bus.dload[0], e_dl[0]);
    check_eq("dload1", bus.dload[1], e_dl[1]);
  endtask

  task automatic tick();
    #1;
    eval_and_check();
    @(posedge CLK);
    m_busy = n_busy; m_data = n_data; m_write = n_write;
    m_core = n_core; m_last = n_last;
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    for (int c = 0; c < 2; c++) begin
      bus.iREN[c] = 0; bus.iaddr[c] = 0; bus.dREN[c] = 0; bus.dWEN[c] = 0;
      bus.daddr[c] = 0; bus.dstore[c] = 0;
    end
    bus.ramload  = 0;
    bus.ramstate = FREE;
  endtask

  initial begin
    int r;
    nRST = 0;
    clear_inputs();
    @(negedge CLK);
    tick();
    #1;
    check_eq("rst_ramREN", 32'(bus.ramREN), 32'd0);
    check_eq("rst_dwait0", 32'(bus.dwait[0]), 32'd1);
    nRST = 1;
    tick();

    // Single read with two BUSY cycles before ACCESS.
    bus.iREN[0] = 1; bus.iaddr[0] = 32'h40;
    tick();
    bus.ramstate = BUSY;
    #1;
    check_eq("rd_ramaddr", bus.ramaddr, 32'h40);
    check_eq("rd_iwait_busy", 32'(bus.iwait[0]), 32'd1);
    tick();
    tick();
    bus.ramstate = ACCESS; bus.ramload = 32'hDEADBEEF;
    #1;
    check_eq("rd_iwait_done", 32'(bus.iwait[0]), 32'd0);
    check_eq("rd_iload", bus.iload[0], 32'hDEADBEEF);
    tick();
    bus.iREN[0] = 0;
    tick();

    // Intra-core priority: data read wins over instruction fetch.
    bus.iREN[1] = 1; bus.iaddr[1] = 32'h44; bus.dREN[1] = 1; bus.daddr[1] = 32'h80;
    tick();
    #1;
    check_eq("prio_ramaddr", bus.ramaddr, 32'h80);
    tick();
    bus.dREN[1] = 0;
    tick();
    #1;
    check_eq("prio_iaddr", bus.ramaddr, 32'h44);
    tick();
    bus.iREN[1] = 0;
    tick();

    // Write from core1.
    bus.dWEN[1] = 1; bus.daddr[1] = 32'h100; bus.dstore[1] = 32'h1234;
    tick();
    #1;
    check_eq("wr_ramWEN", 32'(bus.ramWEN), 32'd1);
    check_eq("wr_ramstore", bus.ramstore, 32'h1234);
    check_eq("wr_dwait1", 32'(bus.dwait[1]), 32'd0);
    tick();
    bus.dWEN[1] = 0;
    tick();

    // Abort while RAM is busy.
    bus.ramstate = BUSY; bus.dREN[0] = 1; bus.daddr[0] = 32'h200;
    tick();
    tick();
    bus.dREN[0] = 0;
    #1;
    check_eq("abort_ramREN", 32'(bus.ramREN), 32'd0);
    check_eq("abort_dwait0", 32'(bus.dwait[0]), 32'd1);
    tick();

    // Randomised traffic.
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if (bus.iREN[c]) begin
          if ((done_i[c] && $urandom_range(0, 1) == 0) || $urandom_range(0, 15) == 0)
            bus.iREN[c] = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          bus.iREN[c] = 1; bus.iaddr[c] = $urandom & ~32'h3;
        end
        if (bus.dREN[c] || bus.dWEN[c]) begin
          if ((done_d[c] && $urandom_range(0, 1) == 0) || $urandom_range(0, 15) == 0) begin
            bus.dREN[c] = 0; bus.dWEN[c] = 0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          r = $urandom_range(0, 2);
          bus.dREN[c]   = (r != 1);
          bus.dWEN[c]   = (r != 0);
          bus.daddr[c]  = $urandom & ~32'h3;
          bus.dstore[c] = $urandom;
        end
      end
      bus.ramstate = $urandom_range(0, 1) ? ACCESS : ramstate_t'($urandom_range(0, 3));
      bus.ramload  = $urandom;
      tick();
    end

    // Reset in the middle of a transfer, then a tie must go to core0.
    clear_inputs();
    tick();
    tick();
    bus.dREN[0] = 1; bus.dREN[1] = 1; bus.daddr[0] = 32'hA0; bus.daddr[1] = 32'hB0;
    bus.ramstate = BUSY;
    tick();
    #2;
    nRST = 0;
    #1;
    check_eq("rst_mid_ramREN", 32'(bus.ramREN), 32'd0);
    check_eq("rst_mid_dwait",
             32'({bus.dwait[0], bus.dwait[1], bus.iwait[0], bus.iwait[1]}), 32'hF);
    tick();
    nRST = 1;
    bus.ramstate = ACCESS;
    tick();
    #1;
    check_eq("rst_tie_core0", bus.ramaddr, 32'hA0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-core memory arbiter between the per-core instruction/data cache ports and the single shared RAM. It accepts one outstanding request per source (core0 I, core0 D, core1 I, core1 D) and serialises them onto the RAM port. Within a core, data beats instruction; between cores, grants rotate round-robin. It sits between the caches feeding each core's `datapath` and the system RAM model.

## Interface
- CPUS, 2, number of cores; fixed at 2 for this revision.
- CLK  in  1  system clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN[CPUS]  in  1 each  instruction read request.
- iaddr[CPUS]  in  32 each  instruction address (word_t).
- dREN[CPUS] / dWEN[CPUS]  in  1 each  data read / write request.
- daddr[CPUS] / dstore[CPUS]  in  32 each  data address / write data.
- iwait[CPUS] / dwait[CPUS]  out  1 each  high = access not complete.
- iload[CPUS] / dload[CPUS]  out  32 each  read data, valid when matching wait is low.
- ramREN / ramWEN  out  1  RAM read / write enable.
- ramaddr / ramstore  out  32  RAM address / write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

## Operation
- States: IDLE, SERVE.
- IDLE: if any request is active, pick a winner, latch it into `grant` (core index plus I/D bit), go SERVE. Otherwise stay in IDLE.
- Core choice: if both cores request, pick the core not equal to `last`. If only one core requests, pick that core.
- Source choice within the chosen core: any of dREN/dWEN beats iREN. If dWEN and dREN are both high, dWEN wins and this is a write.
- SERVE drives the RAM from the latched grant:
  - ramaddr = granted address.
  - ramstore = granted dstore.
  - ramREN = read.
  - ramWEN = write.
- SERVE with ramstate == ACCESS:
  - Completion: lower the granted wait in the same cycle.
  - iload/dload = ramload for that source.
  - `last` <= granted core; go IDLE.
- SERVE with ramstate BUSY, FREE or ERROR: hold and stay in SERVE. ERROR is never reported upward.
- Abort: if the granted request drops in SERVE (its REN/WEN both low), deassert ramREN/ramWEN that cycle and go IDLE. No wait goes low and `last` is unchanged.
- Waits are high at all times except on the completion cycle of the granted source. Waits are also high for idle sources.
- iload/dload for non-granted sources = 0.

## Timing
- Reset (async): state IDLE, grant 0, `last` = 1 (core0 wins the first tie). All waits 1, ramREN = ramWEN = 0, ramaddr = ramstore = 0, loads 0.
- Requests are sampled only in IDLE. A request raised during SERVE waits for the next IDLE.
- Minimum latency: request in cycle N (IDLE), RAM driven in N+1. If ACCESS arrives in N+1, wait is low in N+1 and the state is IDLE in N+2.
- A new grant is possible in N+2, giving one dead IDLE cycle per transfer. Back-to-back requests from different sources therefore complete every 2 cycles at minimum.
- All RAM outputs and the wait/load outputs are combinational from state, grant and ramstate. There are no registered output delays.
- Reset mid-SERVE: RAM enables drop asynchronously and the in-flight access is abandoned.

## Structure
- Reuse word_t and ramstate_t from cpu_types_pkg.
- Add arb_state_t (IDLE, SERVE) and grant_t (packed struct: core index, isData, isWrite) to cpu_types_pkg.
- Single module. Round-robin and priority selection is an always_comb block, not a sub-module.
- Connects to the caches through the existing cache_control_if style bundle extended to arrays of CPUS.

## Test plan
- Single read: core0 iREN=1, iaddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF → ramREN=1 and ramaddr=0x40 from cycle 1; iwait[0]=0 and iload[0]=0xDEADBEEF in cycle 3 only.
- Intra-core priority: core1 iREN=1 and dREN=1 together, daddr=0x80 → first grant has ramaddr=0x80 with ramREN=1; the instruction read is served on the next grant.
- Round-robin: both cores hold dREN continuously, RAM always ACCESS → grants alternate core0, core1, core0, core1; dwait of each core toggles low every 4 cycles.
- Write: core1 dWEN=1, daddr=0x100, dstore=0x1234 → ramWEN=1, ramREN=0, ramstore=0x1234; dwait[1]=0 on ACCESS.
- Abort: core0 dREN drops while ramstate=BUSY in SERVE → ramREN=0 the same cycle, state IDLE next cycle, dwait[0] stays 1, `last` unchanged.
- Reset mid-op: nRST low during SERVE → ramREN/ramWEN drop immediately, all waits 1. After release, a tied request grants core0 first.
